reg_file_mp: RTL and testbench

//  Parametrised multi-read-port register file with write bypass, optional registered reads and
//  a per-register busy scoreboard for pipelined issue. Sits between decode (read/issue) and

---
 rtl/reg_file_mp_if.sv | 29 ++
 rtl/reg_file_mp.sv | 146 ++++++++++++++
 tb/tb_reg_file_mp.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus for the multi-port register file: read ports, writeback
// strobe, issue marking and the busy scoreboard count.
interface reg_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  issue_en;
    logic [AW-1:0]         issue_rd;
    logic [AW:0]           busy_cnt;

    modport master (
        output rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        input  rs_data, rs_busy, busy_cnt
    );

    modport slave (
        input  rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        output rs_data, rs_busy, busy_cnt
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional write bypass, optional registered
// reads and a per-register busy scoreboard for pipelined issue.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_LAT   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [AW:0]           busy_cnt_q;
    logic [AW:0]           busy_cnt_d;
    logic                  wr_ok_s;
    logic                  issue_ok_s;
    logic [AW-1:0]         rd_addr_s [NREAD];
    logic [NREAD*XLEN-1:0] rd_data_d;
    logic [NREAD-1:0]      rs_busy_s;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] c;
        c = {(AW+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Qualify write and issue: register 0 is hardwired when ZERO_REG is set.
    always_comb begin
        wr_ok_s    = bus.wr_en;
        issue_ok_s = bus.issue_en;
        if ((ZERO_REG != 0) && (bus.wr_addr == {AW{1'b0}})) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = bus.wr_en;
        end
        if ((ZERO_REG != 0) && (bus.issue_rd == {AW{1'b0}})) begin
            issue_ok_s = 1'b0;
        end else begin
            issue_ok_s = bus.issue_en;
        end
    end

    // Next register contents and scoreboard; a same-cycle issue beats the clearing write.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            if (wr_ok_s && (bus.wr_addr == AW'(r))) begin
                regs_d[r] = bus.wr_data;
            end else begin
                regs_d[r] = regs_q[r];
            end
            if (issue_ok_s && (bus.issue_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end else begin
            busy_d[0] = busy_d[0];
        end
        busy_cnt_d = popcount(busy_d);
    end

    // Unpack the per-port read addresses.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_addr_s[i] = bus.rs_addr[i*AW +: AW];
        end
    end

    // Combinational read value and busy flag per port, with optional writeback forwarding.
    always_comb begin
        rd_data_d = {(NREAD*XLEN){1'b0}};
        rs_busy_s = {NREAD{1'b0}};
        for (int i = 0; i < NREAD; i++) begin
            if ((ZERO_REG != 0) && (rd_addr_s[i] == {AW{1'b0}})) begin
                rd_data_d[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && wr_ok_s && (bus.wr_addr == rd_addr_s[i])) begin
                rd_data_d[i*XLEN +: XLEN] = bus.wr_data;
            end else begin
                rd_data_d[i*XLEN +: XLEN] = regs_q[rd_addr_s[i]];
            end
            if ((BYPASS != 0) && wr_ok_s && (bus.wr_addr == rd_addr_s[i])) begin
                rs_busy_s[i] = 1'b0;
            end else begin
                rs_busy_s[i] = busy_q[rd_addr_s[i]];
            end
        end
    end

    // Architectural state and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
            busy_q     <= {NREGS{1'b0}};
            busy_cnt_q <= {(AW+1){1'b0}};
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_cap(busy_cnt_d);
        end
    end

    function automatic logic [AW:0] busy_cnt_cap(input logic [AW:0] v);
        return v;
    endfunction

    assign bus.rs_busy  = rs_busy_s;
    assign bus.busy_cnt = busy_cnt_q;

    generate
        if (RD_LAT != 0) begin : g_rd_reg
            logic [NREAD*XLEN-1:0] rd_data_q;

            // Registered read path: data appears one cycle after the address.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= {(NREAD*XLEN){1'b0}};
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end
            assign bus.rs_data = rd_data_q;
        end else begin : g_rd_comb
            assign bus.rs_data = rd_data_d;
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two register-file configurations (zero-reg/bypass/combinational
// and plain/no-bypass/registered) driven with the same stimulus against a reference model.
module tb_reg_file_mp;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus0 ();
    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus1 ();

    reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1), .RD_LAT(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    reg_file_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(0), .BYPASS(0), .RD_LAT(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: index 0 = zero-reg/bypass config, index 1 = plain/no-bypass config
    logic [31:0] m_regs [2][32];
    logic [31:0] m_busy [2];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input int k, input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
        if (k == 0 && a == 5'd0) return 32'h0;
        if (k == 0 && we && wa == a) return wd;
        return m_regs[k][a];
    endfunction

    function automatic logic m_bz(input int k, input logic [4:0] a, input logic we,
                                  input logic [4:0] wa);
        if (k == 0 && we && wa == a && wa != 5'd0) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [5:0] m_cnt(input int k);
        logic [5:0] c;
        c = 6'd0;
        for (int r = 0; r < 32; r++) c = c + {5'd0, m_busy[k][r]};
        return c;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ir,
                         input logic [4:0] a0, input logic [4:0] a1);
        bus0.wr_en = we;  bus0.wr_addr = wa;  bus0.wr_data = wd;
        bus0.issue_en = ie; bus0.issue_rd = ir; bus0.rs_addr = {a1, a0};
        bus1.wr_en = we;  bus1.wr_addr = wa;  bus1.wr_data = wd;
        bus1.issue_en = ie; bus1.issue_rd = ir; bus1.rs_addr = {a1, a0};
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) m_regs[k][r] = 32'h0;
            m_busy[k] = 32'h0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One bus cycle: drive at negedge, check outputs, then advance the model at posedge.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ir,
                         input logic [4:0] a0, input logic [4:0] a1);
        logic [63:0] got;
        @(negedge clk);
        drive(we, wa, wd, ie, ir, a0, a1);
        #1;
        q0.push_back({m_rd(0, a1, we, wa, wd), m_rd(0, a0, we, wa, wd)});
        got = q0.pop_front();
        chk("d0_rs_data", {32'h0, bus0.rs_data}, got);
        chk("d0_rs_busy", {62'h0, bus0.rs_busy}, {62'h0, m_bz(0, a1, we, wa), m_bz(0, a0, we, wa)});
        chk("d0_busy_cnt", {58'h0, bus0.busy_cnt}, {58'h0, m_cnt(0)});
        if (q1.size() == 0) begin
            chk("d1_sb_underflow", 64'd0, 64'd1);
        end else begin
            got = q1.pop_front();
            chk("d1_rs_data", {32'h0, bus1.rs_data}, got);
        end
        q1.push_back({m_rd(1, a1, we, wa, wd), m_rd(1, a0, we, wa, wd)});
        chk("d1_rs_busy", {62'h0, bus1.rs_busy}, {62'h0, m_bz(1, a1, we, wa), m_bz(1, a0, we, wa)});
        chk("d1_busy_cnt", {58'h0, bus1.busy_cnt}, {58'h0, m_cnt(1)});
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (we && !(k == 0 && wa == 5'd0)) m_regs[k][wa] = wd;
            if (we) m_busy[k][wa] = 1'b0;
            if (ie && !(k == 0 && ir == 5'd0)) m_busy[k][ir] = 1'b1;
        end
    endtask

    // Release reset at a negedge with idle inputs; the registered read port then holds 0.
    task automatic reset_release();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_clear();
        rst_n = 1'b1;
        q1.push_back(64'h0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d0_data", {32'h0, bus0.rs_data}, 64'h0);
        chk("rst_d1_data", {32'h0, bus1.rs_data}, 64'h0);
        chk("rst_d0_cnt", {58'h0, bus0.busy_cnt}, 64'h0);
        reset_release();

        // Zero register: writes and issues to r0 are ignored in config 0
        cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1 chk("zr_d0_cnt", {58'h0, bus0.busy_cnt}, 64'h0);
        chk("zr_d1_cnt", {58'h0, bus1.busy_cnt}, 64'h1);

        // Bypass: old r7=0x11, same-cycle write 0x22 read on both ports
        cycle(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
        #1 chk("byp_d1_old", {32'h0, bus1.rs_data}, 64'h00000011_00000011);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        #1 chk("byp_d1_new", {32'h0, bus1.rs_data}, 64'h00000022_00000022);

        // Registered read latency
        cycle(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd1);
        #1 chk("lat_d1_n1", {32'h0, bus1.rs_data[31:0]}, 64'hA5A5A5A5);

        // Scoreboard sequence
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
        cycle(1'b1, 5'd4, 32'h9, 1'b1, 5'd4, 5'd4, 5'd0);
        #1 chk("sb_set_wins", {58'h0, bus0.busy_cnt}, 64'h1);
        cycle(1'b1, 5'd4, 32'h9, 1'b0, 5'd0, 5'd4, 5'd0);
        #1 chk("sb_cleared", {58'h0, bus0.busy_cnt}, 64'h0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd4, 5'd1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2, 5'd1);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd2);
        #1 chk("sb_cnt3", {58'h0, bus0.busy_cnt}, 64'h3);
        cycle(1'b1, 5'd2, 32'h77, 1'b1, 5'd5, 5'd2, 5'd5);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd5);

        // Asynchronous reset mid-run after writing r5
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_d0_data", {32'h0, bus0.rs_data}, 64'h0);
        chk("arst_d1_data", {32'h0, bus1.rs_data}, 64'h0);
        chk("arst_d0_busy", {62'h0, bus0.rs_busy}, 64'h0);
        chk("arst_d1_busy", {62'h0, bus1.rs_busy}, 64'h0);
        chk("arst_d0_cnt", {58'h0, bus0.busy_cnt}, 64'h0);
        chk("arst_d1_cnt", {58'h0, bus1.busy_cnt}, 64'h0);
        reset_release();
        cycle(1'b1, 5'd5, 32'h5A5A0001, 1'b0, 5'd0, 5'd5, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);

        // Random traffic, addresses biased toward a small window to provoke collisions
        for (int n = 0; n < 10000; n++) begin
            logic [4:0] wa, ir, a0, a1;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ir = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? ir : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 2) == 0), ir, a0, a1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
